// File: rtl/usart_sync_rx.sv
// Synchronous-mode USART receiver: samples SLBit on ExClk rising edges (both synchronised into CPU_Clk).
// Define USART_RX_FIFO_EN to replace the single holding register with a FIFO_DEPTH-entry receive FIFO.
module usart_sync_rx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic       CPU_Clk,
    input  logic       Reset,
    input  logic       None,
    input  logic       Rec,
    input  logic       Trans,
    input  logic [5:0] Control,
    input  logic       ExClk,
    input  logic       SLBit,
    output logic [7:0] CPU_Data_out,
    output logic [4:0] Status
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2
    } state_t;

    logic [SYNC_STAGES-1:0] exclk_sync_q;
    logic [SYNC_STAGES-1:0] sl_sync_q;
    logic                   exclk_prev_q;
    logic [5:0]             cfg_q;
    state_t                 state_q;
    logic [2:0]             cnt_q;
    logic [7:0]             shift_q;
    logic                   perr_q;
    logic                   ferr_q;
    logic                   busy_q;

    logic       exclk_s;
    logic       sl_bit;
    logic       bit_event;
    logic       rd_strobe;
    logic       cfg_wr;
    logic       rx_en;
    logic [2:0] last_idx;
    logic       frame_done;
    logic       done_ferr;

    // Both lines see the same synchroniser depth so SLBit is aligned with the detected ExClk edge.
    always_ff @(posedge CPU_Clk or posedge Reset) begin
        if (Reset) begin
            exclk_sync_q <= '1;
            sl_sync_q    <= '1;
            exclk_prev_q <= 1'b1;
        end else begin
            exclk_sync_q <= {exclk_sync_q[SYNC_STAGES-2:0], ExClk};
            sl_sync_q    <= {sl_sync_q[SYNC_STAGES-2:0], SLBit};
            exclk_prev_q <= exclk_sync_q[SYNC_STAGES-1];
        end
    end

    assign exclk_s   = exclk_sync_q[SYNC_STAGES-1];
    assign sl_bit    = sl_sync_q[SYNC_STAGES-1];
    assign bit_event = exclk_s & ~exclk_prev_q;
    assign rd_strobe = None & Rec & ~Trans;
    assign cfg_wr    = None & Rec & Trans;
    assign rx_en     = cfg_q[5];
    assign last_idx  = 3'd4 + {1'b0, cfg_q[1:0]};

    // A frame completes on the bit event of its last stop bit, unless a config write aborts it.
    assign frame_done = bit_event & rx_en & ~cfg_wr &
                        (((state_q == ST_STOP1) & ~cfg_q[4]) | (state_q == ST_STOP2));
    assign done_ferr  = ferr_q | ~sl_bit;

    always_ff @(posedge CPU_Clk or posedge Reset) begin
        if (Reset) begin
            cfg_q   <= 6'b000011;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else if (cfg_wr) begin
            cfg_q   <= Control;
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
        end else if (bit_event && rx_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (!sl_bit) begin
                        state_q <= ST_DATA;
                        cnt_q   <= '0;
                        shift_q <= '0;
                        perr_q  <= 1'b0;
                        ferr_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_q[cnt_q] <= sl_bit;
                    if (cnt_q == last_idx) begin
                        state_q <= cfg_q[2] ? ST_PARITY : ST_STOP1;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                ST_PARITY: begin
                    // Unused MSBs of shift_q are zero, so XOR over all 8 bits covers the data length.
                    perr_q  <= sl_bit ^ (^shift_q) ^ cfg_q[3];
                    state_q <= ST_STOP1;
                end
                ST_STOP1: begin
                    ferr_q <= done_ferr;
                    if (cfg_q[4]) begin
                        state_q <= ST_STOP2;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_STOP2: begin
                    ferr_q  <= done_ferr;
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    logic       out_ready;
    logic       out_ovr;
    logic       out_perr;
    logic       out_ferr;
    logic [7:0] out_data;

`ifdef USART_RX_FIFO_EN
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          ovr_q;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [9:0]    head;

    assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign pop        = rd_strobe & ~fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the frame.
    assign push       = frame_done & (~fifo_full | pop);
    assign head       = mem_q[rd_ptr_q];

    always_ff @(posedge CPU_Clk or posedge Reset) begin
        if (Reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {done_ferr, perr_q, shift_q};
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (frame_done && !push) begin
                ovr_q <= 1'b1;
            end else if (rd_strobe) begin
                ovr_q <= 1'b0;
            end
        end
    end

    assign out_ready = ~fifo_empty;
    assign out_ovr   = ovr_q;
    assign out_data  = fifo_empty ? 8'h00 : head[7:0];
    assign out_perr  = ~fifo_empty & head[8];
    assign out_ferr  = ~fifo_empty & head[9];
`else
    logic [7:0] hold_data_q;
    logic       hold_perr_q;
    logic       hold_ferr_q;
    logic       ready_q;
    logic       ovr_q;
    logic       load;

    assign load = frame_done & (~ready_q | rd_strobe);

    always_ff @(posedge CPU_Clk or posedge Reset) begin
        if (Reset) begin
            hold_data_q <= '0;
            hold_perr_q <= 1'b0;
            hold_ferr_q <= 1'b0;
            ready_q     <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            if (load) begin
                hold_data_q <= shift_q;
                hold_perr_q <= perr_q;
                hold_ferr_q <= done_ferr;
                ready_q     <= 1'b1;
            end else if (rd_strobe) begin
                hold_perr_q <= 1'b0;
                hold_ferr_q <= 1'b0;
                ready_q     <= 1'b0;
            end
            if (frame_done && !load) begin
                ovr_q <= 1'b1;
            end else if (rd_strobe) begin
                ovr_q <= 1'b0;
            end
        end
    end

    assign out_ready = ready_q;
    assign out_ovr   = ovr_q;
    assign out_data  = hold_data_q;
    assign out_perr  = hold_perr_q;
    assign out_ferr  = hold_ferr_q;
`endif

    assign CPU_Data_out = out_data;
    assign Status       = {out_ovr, out_ferr, out_perr, busy_q, out_ready};

endmodule

// File: tb/tb_usart_sync_rx.sv
// Self-checking bench for usart_sync_rx: directed scenarios plus randomized frames against a queue model.
`timescale 1ns/1ps
module tb_usart_sync_rx;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned FIFO_DEPTH  = 4;
`ifdef USART_RX_FIFO_EN
  localparam int unsigned DEPTH = FIFO_DEPTH;
`else
  localparam int unsigned DEPTH = 1;
`endif
  localparam int HALF = 4;

  logic       cpu_clk = 1'b0;
  logic       reset;
  logic       none_c;
  logic       rec_c;
  logic       trans_c;
  logic [5:0] control;
  logic       exclk;
  logic       slbit;
  logic [7:0] data_out;
  logic [4:0] status;

  int checks = 0;
  int errors = 0;

  // Model: each entry is {framing_err, parity_err, data}.
  logic [9:0] exp_q[$];
  logic       exp_ovr;
  logic [5:0] cur_cfg;

  always #5 cpu_clk = ~cpu_clk;

  usart_sync_rx #(.SYNC_STAGES(SYNC_STAGES), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .CPU_Clk(cpu_clk),
    .Reset(reset),
    .None(none_c),
    .Rec(rec_c),
    .Trans(trans_c),
    .Control(control),
    .ExClk(exclk),
    .SLBit(slbit),
    .CPU_Data_out(data_out),
    .Status(status)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge cpu_clk);
    #1;
  endtask

  task automatic cmd_config(input logic [5:0] cfg);
    none_c = 1'b1; rec_c = 1'b1; trans_c = 1'b1; control = cfg;
    tick(1);
    none_c = 1'b0; rec_c = 1'b0; trans_c = 1'b0;
    cur_cfg = cfg;
  endtask

  task automatic cmd_read();
    none_c = 1'b1; rec_c = 1'b1; trans_c = 1'b0;
    tick(1);
    none_c = 1'b0; rec_c = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    exp_ovr = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    slbit = b; exclk = 1'b0;
    tick(HALF);
    exclk = 1'b1;
    tick(HALF);
  endtask

  function automatic int frame_len(input logic [5:0] cfg);
    return 5 + int'(cfg[1:0]);
  endfunction

  // Expected result from the line-level view: parity counts ones, framing checks each stop bit.
  function automatic logic [9:0] frame_entry(input logic [5:0] cfg, input logic [7:0] data,
                                             input logic pbit, input logic s1, input logic s2);
    int len;
    logic [7:0] masked;
    int ones;
    logic perr;
    logic ferr;
    len    = frame_len(cfg);
    masked = data & 8'((1 << len) - 1);
    ones   = $countones(masked) + int'(pbit);
    perr   = cfg[2] && ((ones % 2) != (cfg[3] ? 1 : 0));
    ferr   = !s1 || (cfg[4] && !s2);
    return {ferr, perr, masked};
  endfunction

  function automatic logic [4:0] model_status();
    if (exp_q.size() == 0) return {exp_ovr, 4'b0000};
    return {exp_ovr, exp_q[0][9], exp_q[0][8], 1'b0, 1'b1};
  endfunction

  task automatic send_frame(input logic [7:0] data, input logic pbit, input logic s1, input logic s2);
    send_bit(1'b0);
    for (int i = 0; i < frame_len(cur_cfg); i++) send_bit(data[i]);
    if (cur_cfg[2]) send_bit(pbit);
    send_bit(s1);
    if (cur_cfg[4]) send_bit(s2);
    slbit = 1'b1;
    tick(2);
    if (cur_cfg[5]) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(frame_entry(cur_cfg, data, pbit, s1, s2));
      else exp_ovr = 1'b1;
    end
  endtask

  task automatic drain();
    while (exp_q.size() > 0) cmd_read();
    cmd_read();
  endtask

  task automatic test_reset();
    tick(3);
    checks++;
    if (status !== 5'b00000 || data_out !== 8'h00) begin
      errors++; $display("FAIL reset_held: status %b data %h, want 00000 00", status, data_out);
    end
    reset = 1'b0;
    tick(3);
    checks++;
    if (status !== 5'b00000 || data_out !== 8'h00) begin
      errors++; $display("FAIL reset_released: status %b data %h, want 00000 00", status, data_out);
    end
  endtask

  task automatic test_disabled();
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
    checks++;
    if (status !== 5'b00000) begin
      errors++; $display("FAIL disabled_rx: status %b, want 00000", status);
    end
  endtask

  task automatic test_basic();
    cmd_config(6'b100011);
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    checks++;
    if (status !== 5'b00001 || data_out !== 8'hA5) begin
      errors++; $display("FAIL basic_rx: status %b data %h, want 00001 a5", status, data_out);
    end
    cmd_read();
    checks++;
    if (status !== 5'b00000) begin
      errors++; $display("FAIL basic_read: status %b, want 00000", status);
    end
  endtask

  task automatic test_parity();
    cmd_config(6'b100100);
    send_frame(8'h16, 1'b0, 1'b1, 1'b1);
    checks++;
    if (status !== 5'b00101 || data_out !== 8'h16) begin
      errors++; $display("FAIL parity_bad: status %b data %h, want 00101 16", status, data_out);
    end
    cmd_read();
    send_frame(8'h16, 1'b1, 1'b1, 1'b1);
    checks++;
    if (status !== 5'b00001 || data_out !== 8'h16) begin
      errors++; $display("FAIL parity_good: status %b data %h, want 00001 16", status, data_out);
    end
    cmd_read();
  endtask

  task automatic test_two_stop();
    cmd_config(6'b110011);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    checks++;
    if (status !== 5'b01001 || data_out !== 8'h3C) begin
      errors++; $display("FAIL two_stop_ferr: status %b data %h, want 01001 3c", status, data_out);
    end
    cmd_read();
    checks++;
    if (status !== 5'b00000) begin
      errors++; $display("FAIL two_stop_read: status %b, want 00000", status);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] want;
    cmd_config(6'b100011);
    for (int i = 0; i <= int'(DEPTH); i++) send_frame(8'((i + 1) * 17), 1'b0, 1'b1, 1'b1);
    checks++;
    if (status !== 5'b10001 || data_out !== 8'h11) begin
      errors++; $display("FAIL overrun_set: status %b data %h, want 10001 11", status, data_out);
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      want = 8'((i + 1) * 17);
      checks++;
      if (data_out !== want || status[0] !== 1'b1) begin
        errors++; $display("FAIL overrun_order: data %h ready %b, want %h 1", data_out, status[0], want);
      end
      cmd_read();
    end
    checks++;
    if (status !== 5'b00000) begin
      errors++; $display("FAIL overrun_drained: status %b, want 00000", status);
    end
  endtask

  task automatic test_simul_read();
    logic [7:0] d;
    cmd_config(6'b100011);
    send_frame(8'h66, 1'b0, 1'b1, 1'b1);
    d = 8'h77;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    slbit = 1'b1; exclk = 1'b0;
    tick(HALF);
    exclk = 1'b1;
    tick(SYNC_STAGES);
    checks++;
    if (data_out !== 8'h66 || status !== 5'b00011) begin
      errors++; $display("FAIL simul_before: status %b data %h, want 00011 66", status, data_out);
    end
    none_c = 1'b1; rec_c = 1'b1; trans_c = 1'b0;
    tick(1);
    none_c = 1'b0; rec_c = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back({2'b00, 8'h77});
    checks++;
    if (data_out !== 8'h77 || status !== 5'b00001) begin
      errors++; $display("FAIL simul_after: status %b data %h, want 00001 77", status, data_out);
    end
    tick(HALF);
    drain();
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    cmd_config(6'b100011);
    d = 8'hF0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    reset = 1'b1;
    tick(2);
    checks++;
    if (status !== 5'b00000 || data_out !== 8'h00) begin
      errors++; $display("FAIL reset_mid: status %b data %h, want 00000 00", status, data_out);
    end
    reset = 1'b0;
    exp_q.delete(); exp_ovr = 1'b0; cur_cfg = 6'b000011;
    tick(2);
    cmd_config(6'b100011);
    send_frame(8'h0F, 1'b0, 1'b1, 1'b1);
    checks++;
    if (status !== 5'b00001 || data_out !== 8'h0F) begin
      errors++; $display("FAIL reset_resume: status %b data %h, want 00001 0f", status, data_out);
    end
    cmd_read();
  endtask

  task automatic test_cfg_abort();
    cmd_config(6'b100011);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    checks++;
    if (status[1] !== 1'b1) begin
      errors++; $display("FAIL abort_busy: busy %b, want 1", status[1]);
    end
    cmd_config(6'b100011);
    checks++;
    if (status !== 5'b00000) begin
      errors++; $display("FAIL abort_drop: status %b, want 00000", status);
    end
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    checks++;
    if (status !== 5'b00000) begin
      errors++; $display("FAIL abort_nobyte: status %b, want 00000", status);
    end
  endtask

  task automatic test_random();
    logic [4:0] want_s;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) cmd_config({1'b1, 5'($urandom_range(0, 31))});
      send_frame(8'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
      want_s = model_status();
      checks++;
      if (status !== want_s || (exp_q.size() > 0 && data_out !== exp_q[0][7:0])) begin
        errors++;
        $display("FAIL random_frame %0d: status %b data %h, want %b %h", n, status, data_out, want_s,
                 (exp_q.size() > 0) ? exp_q[0][7:0] : 8'h00);
      end
      if ($urandom_range(0, 1) == 1) begin
        cmd_read();
        want_s = model_status();
        checks++;
        if (status !== want_s || (exp_q.size() > 0 && data_out !== exp_q[0][7:0])) begin
          errors++;
          $display("FAIL random_read %0d: status %b data %h, want %b %h", n, status, data_out, want_s,
                   (exp_q.size() > 0) ? exp_q[0][7:0] : 8'h00);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; none_c = 1'b0; rec_c = 1'b0; trans_c = 1'b0;
    control = 6'b000000; exclk = 1'b1; slbit = 1'b1;
    exp_ovr = 1'b0; cur_cfg = 6'b000011;
    test_reset();
    test_disabled();
    test_basic();
    test_parity();
    test_two_stop();
    test_overrun();
    test_simul_read();
    test_reset_midframe();
    test_cfg_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/usart_sync_rx.md
Name: usart_sync_rx

Overview:
- Dedicated synchronous-mode USART receiver.
- Samples the shared serial line SLBit on rising edges of the external bit clock ExClk, both synchronised into CPU_Clk.
- Deframes start/data/parity/stop bits, presents the received byte and status to the CPU over the None/Rec/Trans command interface.
- Receive-side counterpart to the USART transmitter driving ExClk/SLBit.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on ExClk and SLBit synchronisers (≥2).
- FIFO_DEPTH, 4, receive buffer depth when USART_RX_FIFO_EN is defined (power of 2, ≥2).

Ports:
- CPU_Clk  in  1  sole clock; all state on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- None  in  1  1 = CPU command valid this cycle.
- Rec  in  1  command bit (see Behaviour).
- Trans  in  1  command bit (see Behaviour).
- Control  in  6  configuration word, captured on config command.
- ExClk  in  1  external bit clock, asynchronous to CPU_Clk.
- SLBit  in  1  serial line, idle high, asynchronous.
- CPU_Data_out  out  8  received byte, right-justified, unused MSBs 0.
- Status  out  5  {overrun, framing_err, parity_err, busy, ready}, bit4..bit0.

Behaviour:
- Commands (sampled each CPU_Clk):
  - None=0: no-op.
  - None=1, Rec=1, Trans=0: read strobe.
  - None=1, Rec=1, Trans=1: config write.
  - None=1, Rec=0: ignored.
- Control map:
  - [1:0] data length: 00=5, 01=6, 10=7, 11=8 bits.
  - [2] parity enable.
  - [3] 1=odd, 0=even parity.
  - [4] 1=two stop bits.
  - [5] receiver enable.
- Reset value of config register: 6'b000011 (8 bits, no parity, 1 stop, disabled).
- Reset values: all outputs 0, FSM IDLE, synchroniser flops 1.
- Sampling:
  - ExClk and SLBit each pass through SYNC_STAGES flops, giving equal latency.
  - Bit event = synchronised ExClk 0->1 detected; SLBit sampled in the same cycle.
  - ExClk high and low phases must each be ≥3 CPU_Clk cycles.
- FSM, advancing only on bit events:
  - IDLE: bit=0 and enabled -> DATA, bit count=0, busy=1. bit=1 -> stay.
  - DATA: store bit at position count (LSB first); at count=len-1 -> PARITY if enabled, else STOP1.
  - PARITY: compare against XOR of data bits (inverted for odd); mismatch sets frame parity flag -> STOP1.
  - STOP1: bit=0 sets frame framing flag. Then -> STOP2 if Control[4], else complete.
  - STOP2: same check as STOP1, then complete.
  - Complete: return to IDLE, busy=0.
- Framing error does not resynchronise: a low stop bit does not count as a new start bit.
- Completion, same cycle as the final bit event:
  - Holding register empty: load data and per-frame parity/framing flags, ready=1.
  - Full: discard frame, set overrun=1; holding register unchanged.
- Read strobe:
  - CPU_Data_out is valid while ready=1.
  - Strobe clears ready, parity_err, framing_err and overrun on the next edge.
  - Strobe with ready=0 only clears overrun.
- Read strobe and completion in the same cycle: new frame loads, ready stays 1, no overrun.
- Config write:
  - Updates config next edge and aborts any frame in progress: FSM -> IDLE, busy=0.
  - Holding register and flags are preserved.
- Control[5]=0: FSM held in IDLE; bit events ignored.
- Reset mid-frame: immediate return to reset state; partial frame lost.

Optional Feature:
- Macro: USART_RX_FIFO_EN.
- Defined:
  - Holding register replaced by a FIFO_DEPTH-entry FIFO; each entry is 8 data bits + 2 error flags.
  - ready = FIFO not empty.
  - CPU_Data_out and the error bits show the head entry.
  - Read strobe pops one entry.
  - overrun sets only when a frame completes with the FIFO full; that frame is discarded.
  - Simultaneous pop and push on a full FIFO succeeds without overrun.
  - Config write does not flush the FIFO.
- Undefined: single holding register exactly as above (depth 1).

Test Plan:
- Config 6'b100011, frame start,0xA5 LSB-first,stop at ExClk period 8 CPU_Clk -> Status=00001, CPU_Data_out=8'hA5; read strobe -> Status=00000.
- Config 6'b100100 (5 bits, even parity), data 5'b10110 with parity 0 -> CPU_Data_out=8'h16, parity_err=1; with parity 1 -> parity_err=0.
- Config 6'b110011 (two stop bits), 0x3C with second stop bit 0 -> framing_err=1, ready=1, data=8'h3C.
- Two frames 0x11, 0x22, no read (FIFO undefined) -> data=8'h11, overrun=1. With USART_RX_FIFO_EN, depth 4: five frames 0x01..0x05 -> reads return 01,02,03,04 and overrun=1.
- Read strobe in the exact cycle frame 0x77 completes, with 0x66 held -> CPU_Data_out 0x66 on that cycle, then 0x77 with ready=1, overrun=0.
- Assert Reset after the 4th data bit of 0xF0, release, send 0x0F -> only 0x0F received, no error flags. Config write mid-frame -> busy drops next cycle, no byte delivered.
